// File: rtl/atm_pkg.sv
// Shared encodings for the ATM bank responder: request opcodes, response
// status codes and the responder FSM state type.
package atm_pkg;

    localparam logic [2:0] OP_VERIFY   = 3'd0;
    localparam logic [2:0] OP_WITHDRAW = 3'd1;
    localparam logic [2:0] OP_DEPOSIT  = 3'd2;
    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_END      = 3'd4;

    typedef enum logic [2:0] {
        RS_OK       = 3'd0,
        RS_BAD_PIN  = 3'd1,
        RS_LOCKED   = 3'd2,
        RS_NO_FUNDS = 3'd3,
        RS_OVERFLOW = 3'd4,
        RS_NOT_AUTH = 3'd5,
        RS_LIMIT    = 3'd6,
        RS_BAD_OP   = 3'd7
    } status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/atm_bank_responder_if.sv
// Request/response handshake bundle between the ATM controller (master)
// and the account responder (slave).
interface atm_bank_responder_if #(
    parameter int ACCT_W = 2,
    parameter int BAL_W  = 16,
    parameter int PIN_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ACCT_W-1:0] req_acct;
    logic [PIN_W-1:0]  req_pin;
    logic [BAL_W-1:0]  req_amount;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [BAL_W-1:0]  rsp_balance;

    modport master (
        output req_valid, req_op, req_acct, req_pin, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance
    );

    modport slave (
        input  req_valid, req_op, req_acct, req_pin, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance
    );
endinterface

// File: rtl/atm_acct_bank.sv
// Per-account balance, PIN, fail-counter and lock storage. Provisioning
// writes take priority over transaction updates to the same account.
module atm_acct_bank #(
    parameter int NUM_ACCT = 4,
    parameter int BAL_W    = 16,
    parameter int PIN_W    = 16,
    parameter int ACCT_W   = $clog2(NUM_ACCT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ACCT_W-1:0] cfg_acct,
    input  logic [PIN_W-1:0]  cfg_pin,
    input  logic [BAL_W-1:0]  cfg_bal,
    input  logic              upd_we,
    input  logic [ACCT_W-1:0] upd_acct,
    input  logic [BAL_W-1:0]  upd_bal,
    input  logic [2:0]        upd_fail,
    input  logic              upd_lock,
    input  logic [ACCT_W-1:0] rd_acct,
    output logic [BAL_W-1:0]  rd_bal,
    output logic [PIN_W-1:0]  rd_pin,
    output logic [2:0]        rd_fail,
    output logic              rd_lock
);
    logic [BAL_W-1:0] bal_q  [NUM_ACCT];
    logic [PIN_W-1:0] pin_q  [NUM_ACCT];
    logic [2:0]       fail_q [NUM_ACCT];
    logic             lock_q [NUM_ACCT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                bal_q[i]  <= '0;
                pin_q[i]  <= '0;
                fail_q[i] <= '0;
                lock_q[i] <= 1'b0;
            end
        end else begin
            if (upd_we) begin
                bal_q[upd_acct]  <= upd_bal;
                fail_q[upd_acct] <= upd_fail;
                lock_q[upd_acct] <= upd_lock;
            end
            // Later assignment wins when both ports hit the same account.
            if (cfg_we) begin
                bal_q[cfg_acct]  <= cfg_bal;
                pin_q[cfg_acct]  <= cfg_pin;
                fail_q[cfg_acct] <= '0;
                lock_q[cfg_acct] <= 1'b0;
            end
        end
    end

    assign rd_bal  = bal_q[rd_acct];
    assign rd_pin  = pin_q[rd_acct];
    assign rd_fail = fail_q[rd_acct];
    assign rd_lock = lock_q[rd_acct];
endmodule

// File: rtl/atm_bank_responder.sv
// Account-side responder: executes VERIFY/WITHDRAW/DEPOSIT/BALANCE/END
// requests against the account bank. Define ATM_RESP_LIMIT_EN for the
// per-session withdraw ceiling.
module atm_bank_responder
    import atm_pkg::*;
#(
    parameter int               NUM_ACCT  = 4,
    parameter int               BAL_W     = 16,
    parameter int               PIN_W     = 16,
    parameter int               MAX_TRIES = 3,
    parameter logic [BAL_W-1:0] WD_LIMIT  = 16'd1000,
    parameter int               ACCT_W    = $clog2(NUM_ACCT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ACCT_W-1:0] cfg_acct,
    input  logic [PIN_W-1:0]  cfg_pin,
    input  logic [BAL_W-1:0]  cfg_bal,
    atm_bank_responder_if.slave bus
);
    state_e            state;
    logic [2:0]        lat_op;
    logic [ACCT_W-1:0] lat_acct;
    logic [PIN_W-1:0]  lat_pin;
    logic [BAL_W-1:0]  lat_amt;
    logic              sess_valid;
    logic [ACCT_W-1:0] sess_acct;

    logic [BAL_W-1:0]  rd_bal;
    logic [PIN_W-1:0]  rd_pin;
    logic [2:0]        rd_fail;
    logic              rd_lock;

    status_e           ex_status;
    logic [BAL_W-1:0]  ex_bal;
    logic              upd_we;
    logic [BAL_W-1:0]  upd_bal;
    logic [2:0]        upd_fail;
    logic              upd_lock;
    logic              sess_set;
    logic              sess_clr;
    logic              authorized;
    logic [BAL_W:0]    dep_sum;
    logic [2:0]        fail_nxt;
    logic              cfg_hits_sess;

`ifdef ATM_RESP_LIMIT_EN
    logic [BAL_W:0]    wd_total;
    logic [BAL_W+1:0]  wd_sum;
    logic              over_lim;
    logic              wd_add;

    assign wd_sum   = {1'b0, wd_total} + (BAL_W+2)'(lat_amt);
    assign over_lim = wd_sum > (BAL_W+2)'(WD_LIMIT);
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^WD_LIMIT;
`endif

    atm_acct_bank #(
        .NUM_ACCT (NUM_ACCT),
        .BAL_W    (BAL_W),
        .PIN_W    (PIN_W),
        .ACCT_W   (ACCT_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_acct (cfg_acct),
        .cfg_pin  (cfg_pin),
        .cfg_bal  (cfg_bal),
        .upd_we   (upd_we && (state == ST_EXEC)),
        .upd_acct (lat_acct),
        .upd_bal  (upd_bal),
        .upd_fail (upd_fail),
        .upd_lock (upd_lock),
        .rd_acct  (lat_acct),
        .rd_bal   (rd_bal),
        .rd_pin   (rd_pin),
        .rd_fail  (rd_fail),
        .rd_lock  (rd_lock)
    );

    assign bus.req_ready = (state == ST_IDLE) && !cfg_we;
    assign authorized    = sess_valid && (sess_acct == lat_acct);
    assign dep_sum       = {1'b0, rd_bal} + {1'b0, lat_amt};
    assign fail_nxt      = (rd_fail >= 3'(MAX_TRIES)) ? rd_fail : rd_fail + 3'd1;

    always_comb begin
        ex_status = RS_OK;
        ex_bal    = '0;
        upd_we    = 1'b0;
        upd_bal   = rd_bal;
        upd_fail  = rd_fail;
        upd_lock  = rd_lock;
        sess_set  = 1'b0;
        sess_clr  = 1'b0;
`ifdef ATM_RESP_LIMIT_EN
        wd_add    = 1'b0;
`endif
        case (lat_op)
            OP_VERIFY: begin
                if (rd_lock) begin
                    ex_status = RS_LOCKED;
                end else if (lat_pin == rd_pin) begin
                    ex_bal   = rd_bal;
                    upd_we   = 1'b1;
                    upd_fail = '0;
                    sess_set = 1'b1;
                end else begin
                    ex_status = RS_BAD_PIN;
                    upd_we    = 1'b1;
                    upd_fail  = fail_nxt;
                    upd_lock  = (fail_nxt == 3'(MAX_TRIES));
                    sess_clr  = 1'b1;
                end
            end
            OP_WITHDRAW: begin
                if (!authorized) begin
                    ex_status = RS_NOT_AUTH;
                end
`ifdef ATM_RESP_LIMIT_EN
                else if (over_lim) begin
                    ex_status = RS_LIMIT;
                    ex_bal    = rd_bal;
                end
`endif
                else if (lat_amt > rd_bal) begin
                    ex_status = RS_NO_FUNDS;
                    ex_bal    = rd_bal;
                end else begin
                    upd_we  = 1'b1;
                    upd_bal = rd_bal - lat_amt;
                    ex_bal  = rd_bal - lat_amt;
`ifdef ATM_RESP_LIMIT_EN
                    wd_add  = 1'b1;
`endif
                end
            end
            OP_DEPOSIT: begin
                if (!authorized) begin
                    ex_status = RS_NOT_AUTH;
                end else if (dep_sum[BAL_W]) begin
                    ex_status = RS_OVERFLOW;
                    ex_bal    = rd_bal;
                end else begin
                    upd_we  = 1'b1;
                    upd_bal = dep_sum[BAL_W-1:0];
                    ex_bal  = dep_sum[BAL_W-1:0];
                end
            end
            OP_BALANCE: begin
                if (!authorized) begin
                    ex_status = RS_NOT_AUTH;
                end else begin
                    ex_bal = rd_bal;
                end
            end
            OP_END: begin
                sess_clr = 1'b1;
            end
            default: begin
                ex_status = RS_BAD_OP;
            end
        endcase
    end

    // Provisioning kills a session on the account it rewrites, including one
    // being opened by a VERIFY in the same cycle.
    assign cfg_hits_sess = cfg_we &&
        (((state == ST_EXEC) && sess_set) ? (cfg_acct == lat_acct) : (cfg_acct == sess_acct));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            lat_op          <= '0;
            lat_acct        <= '0;
            lat_pin         <= '0;
            lat_amt         <= '0;
            sess_valid      <= 1'b0;
            sess_acct       <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_status  <= '0;
            bus.rsp_balance <= '0;
`ifdef ATM_RESP_LIMIT_EN
            wd_total        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        lat_op   <= bus.req_op;
                        lat_acct <= bus.req_acct;
                        lat_pin  <= bus.req_pin;
                        lat_amt  <= bus.req_amount;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    bus.rsp_status  <= ex_status;
                    bus.rsp_balance <= ex_bal;
                    bus.rsp_valid   <= 1'b1;
                    state           <= ST_RESP;
                    if (sess_set) begin
                        sess_valid <= 1'b1;
                        sess_acct  <= lat_acct;
                    end
                    if (sess_clr) begin
                        sess_valid <= 1'b0;
                    end
`ifdef ATM_RESP_LIMIT_EN
                    if (sess_set || sess_clr) begin
                        wd_total <= '0;
                    end else if (wd_add) begin
                        wd_total <= wd_sum[BAL_W:0];
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (cfg_hits_sess) begin
                sess_valid <= 1'b0;
`ifdef ATM_RESP_LIMIT_EN
                wd_total   <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed plus randomized bench for atm_bank_responder against an
// account-level reference model.
module tb_atm_bank_responder;
    localparam int MAX_TRIES = 3;
    localparam int WD_LIM    = 1000;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_acct;
    logic [15:0] cfg_pin;
    logic [15:0] cfg_bal;

    int total;
    int bad;

    int  mb [4];
    int  mp [4];
    int  mf [4];
    bit  sv;
    int  sa;
    int  wd;

    atm_bank_responder_if #(.ACCT_W(2), .BAL_W(16), .PIN_W(16)) bus ();

    atm_bank_responder #(
        .NUM_ACCT  (4),
        .BAL_W     (16),
        .PIN_W     (16),
        .MAX_TRIES (MAX_TRIES),
        .WD_LIMIT  (16'd1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_acct (cfg_acct),
        .cfg_pin  (cfg_pin),
        .cfg_bal  (cfg_bal),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mb[i] = 0; mp[i] = 0; mf[i] = 0;
        end
        sv = 0; sa = 0; wd = 0;
    endtask

    task automatic model_prov(input int a, input int pin, input int bal);
        mp[a] = pin; mb[a] = bal; mf[a] = 0;
        if (sv && sa == a) begin
            sv = 0; wd = 0;
        end
    endtask

    task automatic model_txn(input int op, input int a, input int pin, input int amt,
                             output logic [2:0] st, output logic [15:0] bal);
        bit auth;
        auth = sv && (sa == a);
        st = 3'd0; bal = 16'd0;
        case (op)
            0: begin
                if (mf[a] >= MAX_TRIES) st = 3'd2;
                else if (pin == mp[a]) begin
                    bal = 16'(mb[a]); mf[a] = 0; sv = 1; sa = a; wd = 0;
                end else begin
                    st = 3'd1; mf[a] = (mf[a] + 1 > MAX_TRIES) ? MAX_TRIES : mf[a] + 1;
                    sv = 0; wd = 0;
                end
            end
            1: begin
                if (!auth) st = 3'd5;
`ifdef ATM_RESP_LIMIT_EN
                else if (wd + amt > WD_LIM) begin st = 3'd6; bal = 16'(mb[a]); end
`endif
                else if (amt > mb[a]) begin st = 3'd3; bal = 16'(mb[a]); end
                else begin mb[a] -= amt; wd += amt; bal = 16'(mb[a]); end
            end
            2: begin
                if (!auth) st = 3'd5;
                else if (mb[a] + amt > 65535) begin st = 3'd4; bal = 16'(mb[a]); end
                else begin mb[a] += amt; bal = 16'(mb[a]); end
            end
            3: begin
                if (!auth) st = 3'd5;
                else bal = 16'(mb[a]);
            end
            4: begin sv = 0; wd = 0; end
            default: st = 3'd7;
        endcase
    endtask

    task automatic prov(input logic [1:0] a, input logic [15:0] pin, input logic [15:0] bal);
        @(negedge clk);
        cfg_we = 1'b1; cfg_acct = a; cfg_pin = pin; cfg_bal = bal;
        #1;
        chk("cfg_blocks_ready", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_prov(a, pin, bal);
    endtask

    task automatic txn(input logic [2:0] op, input logic [1:0] a, input logic [15:0] pin,
                       input logic [15:0] amt, input string tag, input bit cfg_mid = 1'b0,
                       input logic [15:0] c_pin = 16'd0, input logic [15:0] c_bal = 16'd0);
        logic [2:0]  es;
        logic [15:0] eb;
        int n;
        model_txn(op, a, pin, amt, es, eb);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_acct = a;
        bus.req_pin = pin; bus.req_amount = amt;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (cfg_mid) begin
            cfg_we = 1'b1; cfg_acct = a; cfg_pin = c_pin; cfg_bal = c_bal;
            model_prov(a, c_pin, c_bal);
        end
        @(negedge clk);
        chk({tag, "_exec_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, "_exec_ready"}, bus.req_ready, 1'b0);
        if (cfg_mid) begin
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        n = 0;
        while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, bus.rsp_valid, 1'b1);
        chk({tag, "_status"}, bus.rsp_status, es);
        chk({tag, "_bal"}, bus.rsp_balance, eb);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [1:0]  a;
        logic [15:0] pin;
        logic [15:0] amt;
        logic [2:0]  es;
        logic [15:0] eb;
        int r;
        int n;
        total = 0; bad = 0;
        rst = 1'b0; cfg_we = 1'b0; cfg_acct = '0; cfg_pin = '0; cfg_bal = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_acct = '0;
        bus.req_pin = '0; bus.req_amount = '0; bus.rsp_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_status", bus.rsp_status, 3'd0);
        chk("rst_rsp_bal", bus.rsp_balance, 16'd0);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);

        prov(2'd1, 16'h1234, 16'd500);
        txn(3'd0, 2'd1, 16'h1234, 16'd0, "tp_verify");
        txn(3'd1, 2'd1, 16'h0, 16'd200, "tp_withdraw");
        txn(3'd4, 2'd1, 16'h0, 16'd0, "tp_end");

        prov(2'd2, 16'hBEEF, 16'd77);
        txn(3'd0, 2'd2, 16'h1111, 16'd0, "lock_w1");
        txn(3'd0, 2'd2, 16'h2222, 16'd0, "lock_w2");
        txn(3'd0, 2'd2, 16'h3333, 16'd0, "lock_w3");
        txn(3'd0, 2'd2, 16'hBEEF, 16'd0, "lock_good");
        prov(2'd2, 16'hBEEF, 16'd77);
        txn(3'd0, 2'd2, 16'hBEEF, 16'd0, "unlock_verify");

        txn(3'd4, 2'd2, 16'h0, 16'd0, "end2");
        txn(3'd1, 2'd1, 16'h0, 16'd1, "noauth_wd");
        txn(3'd4, 2'd0, 16'h0, 16'd0, "end_nosess");
        txn(3'd0, 2'd1, 16'h1234, 16'd0, "verify1");
        txn(3'd3, 2'd0, 16'h0, 16'd0, "noauth_bal");
        txn(3'd7, 2'd1, 16'h0, 16'd0, "bad_op");
        txn(3'd1, 2'd1, 16'h0, 16'd301, "no_funds");
        txn(3'd1, 2'd1, 16'h0, 16'd0, "wd_zero");

        prov(2'd3, 16'h5555, 16'hFFF0);
        txn(3'd0, 2'd3, 16'h5555, 16'd0, "verify3");
        txn(3'd2, 2'd3, 16'h0, 16'h0010, "overflow");
        txn(3'd2, 2'd3, 16'h0, 16'h000F, "dep_max");

        prov(2'd0, 16'h0A0A, 16'd5000);
        txn(3'd0, 2'd0, 16'h0A0A, 16'd0, "verify0");
        txn(3'd1, 2'd0, 16'h0, 16'd600, "lim_600");
        txn(3'd1, 2'd0, 16'h0, 16'd500, "lim_500");
        txn(3'd1, 2'd0, 16'h0, 16'd400, "lim_400");

        // Provisioning lands while the withdraw is executing.
        txn(3'd0, 2'd1, 16'h1234, 16'd0, "mid_verify");
        txn(3'd1, 2'd1, 16'h0, 16'd10, "mid_wd", 1'b1, 16'h4321, 16'd999);
        txn(3'd3, 2'd1, 16'h0, 16'd0, "mid_bal_noauth");
        txn(3'd0, 2'd1, 16'h4321, 16'd0, "mid_reverify");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            if (r < 8) begin
                prov(a, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 2000)));
            end else begin
                r = $urandom_range(0, 9);
                if (r < 3) op = 3'd0;
                else if (r < 5) op = 3'd1;
                else if (r < 7) op = 3'd2;
                else if (r == 7) op = 3'd3;
                else if (r == 8) op = 3'd4;
                else op = 3'($urandom_range(5, 7));
                if (op != 3'd0 && sv && $urandom_range(0, 3) != 0) a = 2'(sa);
                pin = ($urandom_range(0, 3) != 0) ? 16'(mp[a]) : 16'($urandom_range(0, 3));
                amt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 700));
                txn(op, a, pin, amt, "rand");
            end
        end

        // Back-pressure then reset in the middle of a held response.
        prov(2'd1, 16'h0777, 16'd321);
        txn(3'd0, 2'd1, 16'h0777, 16'd0, "bp_verify");
        model_txn(3, 1, 0, 0, es, eb);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_acct = 2'd1;
        @(posedge clk); #1;
        bus.req_op = 3'd2; bus.req_amount = 16'd5;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_status", bus.rsp_status, es);
            chk("bp_bal", bus.rsp_balance, eb);
            chk("bp_req_ready", bus.req_ready, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_status", bus.rsp_status, 3'd0);
        chk("mid_rst_bal", bus.rsp_balance, 16'd0);
        bus.req_valid = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b1;
        #1;
        chk("post_rst_ready", bus.req_ready, 1'b1);
        txn(3'd3, 2'd1, 16'h0, 16'd0, "post_rst_noauth");
        txn(3'd0, 2'd1, 16'h0, 16'd0, "post_rst_v1");
        txn(3'd0, 2'd3, 16'h0, 16'd0, "post_rst_v3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
